uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//  Downstream of the UART receiver: consumes its parallel byte stream (data + valid pulse + error flags)
//  and decodes multi-byte command frames into register-file read/write strobes and ALU operation requests.
//  Single clock domain. Inputs are already synchronised to CLK.
// PARAMETERS
//  DATA_WIDTH   8      byte width of RX data, WR_DATA and operands
//  ADDR_WIDTH   4      register-file address width; taken from the low bits of the address byte
//  FUN_WIDTH    4      ALU function width; taken from the low bits of the function byte
//  TIMEOUT_CYC  50000  idle CLK cycles allowed between bytes of one frame (>=2)
// PORTS
//  CLK        in   1           system clock
//  RST        in   1           synchronous reset, active-high
//  RX_P_DATA  in   DATA_WIDTH  received byte
//  RX_D_VLD   in   1           one-cycle pulse: RX_P_DATA valid
//  PAR_ERR    in   1           parity error, qualified by RX_D_VLD
//  FRM_ERR    in   1           framing error, qualified by RX_D_VLD
//  WR_EN      out  1           reg-file write strobe, 1 cycle
//  RD_EN      out  1           reg-file read strobe, 1 cycle
//  ADDR       out  ADDR_WIDTH  reg-file address
//  WR_DATA    out  DATA_WIDTH  reg-file write data
//  ALU_EN     out  1           ALU request strobe, 1 cycle
//  ALU_FUN    out  FUN_WIDTH   ALU function code
//  OP_A       out  DATA_WIDTH  ALU operand A
//  OP_B       out  DATA_WIDTH  ALU operand B
//  BUSY       out  1           high while a frame is partially received
//  CMD_ERR    out  1           1-cycle pulse: frame rejected/aborted
// BEHAVIOUR
//  - Reset: every output 0, FSM -> IDLE, timeout counter 0. Reset mid-frame discards the partial frame; no strobe.
//  - Frames (first byte = command):
//      0xAA: ADDR, DATA      -> WR_EN
//      0xBB: ADDR            -> RD_EN
//      0xCC: OPA, OPB, FUN   -> ALU_EN, OP_A/OP_B updated
//      0xDD: FUN             -> ALU_EN, OP_A/OP_B keep their previous values
//  - States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN. One byte accepted per RX_D_VLD pulse.
//      IDLE    -> WR_ADDR (0xAA) | RD_ADDR (0xBB) | ALU_OPA (0xCC) | ALU_FUN (0xDD)
//      IDLE    + any other byte -> CMD_ERR pulse next cycle; stay IDLE
//      WR_ADDR -> WR_DATA;  ALU_OPA -> ALU_OPB -> ALU_FUN
//      WR_DATA, RD_ADDR, ALU_FUN -> IDLE on accept
//  - Latency: strobe (WR_EN/RD_EN/ALU_EN) is high exactly one cycle, in the cycle after the RX_D_VLD of the final byte.
//  - Registered outputs: ADDR, WR_DATA, OP_A, OP_B, ALU_FUN are registered as their bytes arrive
//    and hold until overwritten. Valid no later than their strobe cycle.
//  - Width rules: ADDR = byte[ADDR_WIDTH-1:0]; ALU_FUN = byte[FUN_WIDTH-1:0]. Upper bits are ignored, no error.
//  - BUSY: registered, 1 in any non-IDLE state, 0 in the strobe cycle (FSM already back in IDLE).
//  - Timeout: counter clears on every RX_D_VLD and is held at 0 in IDLE. It increments otherwise.
//    On reaching TIMEOUT_CYC-1 in a non-IDLE state: FSM -> IDLE, CMD_ERR pulse, no strobe.
//  - Simultaneous RX_D_VLD and timeout expiry: the byte wins (accepted, counter cleared, no error).
//  - Back-to-back frames: a command byte arriving in the strobe cycle is accepted normally.
// CONFIGURATION
//  UART_CMD_ERR_DROP_EN defined:
//    - A byte with RX_D_VLD && (PAR_ERR || FRM_ERR) is discarded in any state.
//    - FSM -> IDLE, CMD_ERR pulse, no strobe, data registers unchanged.
//  UART_CMD_ERR_DROP_EN undefined:
//    - PAR_ERR/FRM_ERR are ignored (ports kept; tied off internally); the byte is processed normally.
// TESTING
//  1. Bytes AA,05,3C -> one-cycle WR_EN, ADDR=5, WR_DATA=3C; BUSY high from first byte until strobe cycle.
//  2. Bytes BB,1A -> RD_EN one cycle, ADDR=A (upper nibble dropped), CMD_ERR stays 0.
//  3. Bytes CC,12,34,02 then DD,03 -> ALU_EN with A=12,B=34,FUN=2; second ALU_EN with A=12,B=34,FUN=3.
//  4. Byte 7E in IDLE -> CMD_ERR pulse, no strobes. AA,05 then silence TIMEOUT_CYC cycles -> CMD_ERR, BUSY=0, no WR_EN.
//  5. RST asserted after CC,11 -> all outputs 0 next cycle. A following DD,01 -> ALU_EN with OP_A=0, OP_B=0.
//  6. AA,05,3C with PAR_ERR on byte 3C: with _EN -> CMD_ERR, no WR_EN, WR_DATA unchanged; without -> WR_EN, WR_DATA=3C.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
//
// Sits behind a UART receiver and turns its byte stream into register-file
// read/write strobes and ALU operation requests. Frames start with a
// command byte:
//   0xAA ADDR DATA      -> WR_EN  (ADDR, WR_DATA updated)
//   0xBB ADDR           -> RD_EN  (ADDR updated)
//   0xCC OPA OPB FUN    -> ALU_EN (OP_A, OP_B, ALU_FUN updated)
//   0xDD FUN            -> ALU_EN (ALU_FUN updated, operands reused)
// Any other byte in IDLE is rejected with a CMD_ERR pulse.
//
// If a frame stalls for TIMEOUT_CYC cycles between bytes, it is abandoned
// and CMD_ERR is pulsed.
//
// Optional feature (macro UART_CMD_ERR_DROP_EN):
//   When defined, a byte that arrives with PAR_ERR or FRM_ERR aborts the
//   current frame: the FSM returns to IDLE, CMD_ERR pulses and no data
//   register changes. When undefined, the error flags are ignored.
//
// Ports
//   CLK        in   system clock
//   RST        in   synchronous active-high reset
//   RX_P_DATA  in   received byte
//   RX_D_VLD   in   one-cycle valid pulse for RX_P_DATA
//   PAR_ERR    in   parity error, qualified by RX_D_VLD
//   FRM_ERR    in   framing error, qualified by RX_D_VLD
//   WR_EN      out  register-file write strobe (1 cycle)
//   RD_EN      out  register-file read strobe (1 cycle)
//   ADDR       out  register-file address
//   WR_DATA    out  register-file write data
//   ALU_EN     out  ALU request strobe (1 cycle)
//   ALU_FUN    out  ALU function code
//   OP_A       out  ALU operand A
//   OP_B       out  ALU operand B
//   BUSY       out  high while a frame is partially received
//   CMD_ERR    out  1-cycle pulse when a frame is rejected or aborted
// ---------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUN_WIDTH   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  FRM_ERR,
    output logic                  WR_EN,
    output logic                  RD_EN,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic [DATA_WIDTH-1:0] OP_A,
    output logic [DATA_WIDTH-1:0] OP_B,
    output logic                  BUSY,
    output logic                  CMD_ERR
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_FUN = DATA_WIDTH'(8'hDD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA_S,
        RD_ADDR,
        ALU_OPA,
        ALU_OPB,
        ALU_FUN_S
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             byte_err;

`ifdef UART_CMD_ERR_DROP_EN
    assign byte_err = PAR_ERR | FRM_ERR;
`else
    // Error flags are deliberately ignored in this build; the port pair is
    // folded into a sink so the inputs are still formally consumed.
    logic unused_err_flags;
    assign unused_err_flags = PAR_ERR ^ FRM_ERR;
    assign byte_err         = 1'b0;
`endif

    // Whole decoder lives in one registered block. Strobes and CMD_ERR
    // default low each cycle so they can only ever be one cycle wide.
    // BUSY is updated together with every state change so it reflects the
    // state being entered, which keeps it low in the strobe cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            WR_EN   <= 1'b0;
            RD_EN   <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;
            BUSY    <= 1'b0;
            ADDR    <= '0;
            WR_DATA <= '0;
            ALU_FUN <= '0;
            OP_A    <= '0;
            OP_B    <= '0;
        end else begin
            WR_EN   <= 1'b0;
            RD_EN   <= 1'b0;
            ALU_EN  <= 1'b0;
            CMD_ERR <= 1'b0;

            if (RX_D_VLD) begin
                // A byte always restarts the inter-byte timer, even when it
                // coincides with expiry: the byte wins.
                tmo_cnt <= '0;
                if (byte_err) begin
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    CMD_ERR <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            if (RX_P_DATA == CMD_WR) begin
                                state <= WR_ADDR;
                                BUSY  <= 1'b1;
                            end else if (RX_P_DATA == CMD_RD) begin
                                state <= RD_ADDR;
                                BUSY  <= 1'b1;
                            end else if (RX_P_DATA == CMD_ALU) begin
                                state <= ALU_OPA;
                                BUSY  <= 1'b1;
                            end else if (RX_P_DATA == CMD_ALU_FUN) begin
                                state <= ALU_FUN_S;
                                BUSY  <= 1'b1;
                            end else begin
                                CMD_ERR <= 1'b1;
                            end
                        end
                        WR_ADDR: begin
                            ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state <= WR_DATA_S;
                        end
                        WR_DATA_S: begin
                            WR_DATA <= RX_P_DATA;
                            WR_EN   <= 1'b1;
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                        end
                        RD_ADDR: begin
                            ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RD_EN <= 1'b1;
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                        ALU_OPA: begin
                            OP_A  <= RX_P_DATA;
                            state <= ALU_OPB;
                        end
                        ALU_OPB: begin
                            OP_B  <= RX_P_DATA;
                            state <= ALU_FUN_S;
                        end
                        ALU_FUN_S: begin
                            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                            ALU_EN  <= 1'b1;
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                        end
                        default: begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    endcase
                end
            end else if (state != IDLE) begin
                // Stalled mid-frame: count idle cycles and abandon the
                // frame once the budget is used up.
                if (tmo_cnt == CNT_LAST) begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                    BUSY    <= 1'b0;
                    CMD_ERR <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
//
// Directed self-checking bench for uart_cmd_decoder. Bytes are driven at the
// falling edge and held for one full cycle, so each byte is seen by exactly
// one rising edge; outputs are sampled at falling edges. The decoder is
// built with a short timeout so stall cases run quickly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

    localparam int TMO = 20;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       PAR_ERR;
    logic       FRM_ERR;
    logic       WR_EN;
    logic       RD_EN;
    logic [3:0] ADDR;
    logic [7:0] WR_DATA;
    logic       ALU_EN;
    logic [3:0] ALU_FUN;
    logic [7:0] OP_A;
    logic [7:0] OP_B;
    logic       BUSY;
    logic       CMD_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uart_cmd_decoder #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .FUN_WIDTH  (4),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD (RX_D_VLD),
        .PAR_ERR  (PAR_ERR),
        .FRM_ERR  (FRM_ERR),
        .WR_EN    (WR_EN),
        .RD_EN    (RD_EN),
        .ADDR     (ADDR),
        .WR_DATA  (WR_DATA),
        .ALU_EN   (ALU_EN),
        .ALU_FUN  (ALU_FUN),
        .OP_A     (OP_A),
        .OP_B     (OP_B),
        .BUSY     (BUSY),
        .CMD_ERR  (CMD_ERR)
    );

    // Present one byte for one cycle; returns at the next falling edge with
    // the byte already captured, leaving RX_D_VLD high so calls chain
    // back-to-back. Callers drop RX_D_VLD themselves to end a burst.
    task automatic put(input logic [7:0] b, input logic pe, input logic fe);
        RX_P_DATA = b;
        PAR_ERR   = pe;
        FRM_ERR   = fe;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
    endtask

    task automatic stop_rx();
        RX_D_VLD = 1'b0;
        PAR_ERR  = 1'b0;
        FRM_ERR  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        stop_rx();
        RX_P_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR});
        end
        n_checks++;
        if ({ADDR, WR_DATA, ALU_FUN, OP_A, OP_B} !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got %h expected 00000000", {ADDR, WR_DATA, ALU_FUN, OP_A, OP_B});
        end
    endtask

    task automatic test_write();
        put(8'hAA, 1'b0, 1'b0);
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy_cmd: got %b expected 1", BUSY); end
        put(8'h05, 1'b0, 1'b0);
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy_addr: got %b expected 1", BUSY); end
        put(8'h3C, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR} !== 5'b10000) begin
            n_fail++;
            $display("[TB] FAIL wr_strobe: got %b expected 10000", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR});
        end
        n_checks++;
        if ({ADDR, WR_DATA} !== 12'h53C) begin
            n_fail++;
            $display("[TB] FAIL wr_data: got %h expected 53c", {ADDR, WR_DATA});
        end
        @(negedge CLK);
        n_checks++;
        if (WR_EN !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_one_cycle: got %b expected 0", WR_EN); end
    endtask

    task automatic test_read();
        put(8'hBB, 1'b0, 1'b0);
        put(8'h1A, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR} !== 5'b01000) begin
            n_fail++;
            $display("[TB] FAIL rd_strobe: got %b expected 01000", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR});
        end
        n_checks++;
        if (ADDR !== 4'hA) begin n_fail++; $display("[TB] FAIL rd_addr: got %h expected a", ADDR); end
        @(negedge CLK);
        n_checks++;
        if ({RD_EN, CMD_ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL rd_one_cycle: got %b expected 00", {RD_EN, CMD_ERR});
        end
    endtask

    task automatic test_alu();
        put(8'hCC, 1'b0, 1'b0);
        put(8'h12, 1'b0, 1'b0);
        put(8'h34, 1'b0, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR} !== 5'b00100) begin
            n_fail++;
            $display("[TB] FAIL alu_strobe: got %b expected 00100", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR});
        end
        n_checks++;
        if ({OP_A, OP_B, ALU_FUN} !== 20'h12342) begin
            n_fail++;
            $display("[TB] FAIL alu_ops: got %h expected 12342", {OP_A, OP_B, ALU_FUN});
        end
        @(negedge CLK);
        put(8'hDD, 1'b0, 1'b0);
        put(8'h03, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if (ALU_EN !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_fun_strobe: got %b expected 1", ALU_EN); end
        n_checks++;
        if ({OP_A, OP_B, ALU_FUN} !== 20'h12343) begin
            n_fail++;
            $display("[TB] FAIL alu_fun_ops: got %h expected 12343", {OP_A, OP_B, ALU_FUN});
        end
        @(negedge CLK);
    endtask

    task automatic test_bad_cmd();
        put(8'h7E, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR} !== 5'b00001) begin
            n_fail++;
            $display("[TB] FAIL bad_cmd: got %b expected 00001", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR});
        end
        @(negedge CLK);
        n_checks++;
        if (CMD_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_cmd_pulse: got %b expected 0", CMD_ERR); end
    endtask

    task automatic test_timeout();
        int strobes = 0;
        put(8'hAA, 1'b0, 1'b0);
        put(8'h05, 1'b0, 1'b0);
        stop_rx();
        // TMO-1 silent cycles: frame still alive
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge CLK);
            if (WR_EN || CMD_ERR) strobes++;
        end
        n_checks++;
        if ({BUSY, strobes} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("[TB] FAIL tmo_alive: busy %b events %0d expected busy 1 events 0", BUSY, strobes);
        end
        @(negedge CLK);
        n_checks++;
        if ({WR_EN, BUSY, CMD_ERR} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL tmo_expire: got %b expected 001", {WR_EN, BUSY, CMD_ERR});
        end
        @(negedge CLK);
        n_checks++;
        if ({WR_EN, CMD_ERR} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL tmo_pulse: got %b expected 00", {WR_EN, CMD_ERR});
        end
    endtask

    task automatic test_byte_beats_timeout();
        int errs = 0;
        put(8'hAA, 1'b0, 1'b0);
        stop_rx();
        // Counter reaches its last value; the next byte lands on expiry
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge CLK);
            if (CMD_ERR) errs++;
        end
        put(8'h09, 1'b0, 1'b0);
        if (CMD_ERR) errs++;
        put(8'h66, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({WR_EN, CMD_ERR, ADDR, WR_DATA} !== {2'b10, 12'h966}) begin
            n_fail++;
            $display("[TB] FAIL tmo_race: got %b %h expected 10 966", {WR_EN, CMD_ERR}, {ADDR, WR_DATA});
        end
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("[TB] FAIL tmo_race_err: got %0d expected 0", errs); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_frame();
        put(8'hCC, 1'b0, 1'b0);
        put(8'h11, 1'b0, 1'b0);
        stop_rx();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR, ADDR, WR_DATA, ALU_FUN, OP_A, OP_B} !== 37'h0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid: got %b %h expected all zero", {WR_EN, RD_EN, ALU_EN, BUSY, CMD_ERR},
                     {ADDR, WR_DATA, ALU_FUN, OP_A, OP_B});
        end
        put(8'hDD, 1'b0, 1'b0);
        put(8'h01, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({ALU_EN, OP_A, OP_B, ALU_FUN} !== {1'b1, 20'h00001}) begin
            n_fail++;
            $display("[TB] FAIL rst_then_alu: got %b %h expected 1 00001", ALU_EN, {OP_A, OP_B, ALU_FUN});
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        put(8'hAA, 1'b0, 1'b0);
        put(8'h07, 1'b0, 1'b0);
        put(8'h55, 1'b0, 1'b0);
        n_checks++;
        if ({WR_EN, BUSY, ADDR, WR_DATA} !== {2'b10, 12'h755}) begin
            n_fail++;
            $display("[TB] FAIL b2b_wr: got %b %h expected 10 755", {WR_EN, BUSY}, {ADDR, WR_DATA});
        end
        put(8'hBB, 1'b0, 1'b0);
        n_checks++;
        if ({WR_EN, BUSY} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL b2b_cmd: got %b expected 01", {WR_EN, BUSY});
        end
        put(8'h01, 1'b0, 1'b0);
        stop_rx();
        n_checks++;
        if ({RD_EN, CMD_ERR, ADDR} !== {2'b10, 4'h1}) begin
            n_fail++;
            $display("[TB] FAIL b2b_rd: got %b %h expected 10 1", {RD_EN, CMD_ERR}, ADDR);
        end
        @(negedge CLK);
    endtask

    task automatic test_rx_error();
        put(8'hAA, 1'b0, 1'b0);
        put(8'h05, 1'b0, 1'b0);
        put(8'h77, 1'b0, 1'b0);
        stop_rx();
        @(negedge CLK);
        put(8'hAA, 1'b0, 1'b0);
        put(8'h05, 1'b0, 1'b0);
        put(8'h3C, 1'b1, 1'b0);
        stop_rx();
`ifdef UART_CMD_ERR_DROP_EN
        n_checks++;
        if ({WR_EN, BUSY, CMD_ERR, WR_DATA} !== {3'b001, 8'h77}) begin
            n_fail++;
            $display("[TB] FAIL par_drop: got %b %h expected 001 77", {WR_EN, BUSY, CMD_ERR}, WR_DATA);
        end
        @(negedge CLK);
        // framing error on the first data byte of a read aborts it too
        put(8'hBB, 1'b0, 1'b0);
        put(8'h03, 1'b0, 1'b1);
        stop_rx();
        n_checks++;
        if ({RD_EN, BUSY, CMD_ERR, ADDR} !== {3'b001, 4'h5}) begin
            n_fail++;
            $display("[TB] FAIL frm_drop: got %b %h expected 001 5", {RD_EN, BUSY, CMD_ERR}, ADDR);
        end
`else
        n_checks++;
        if ({WR_EN, BUSY, CMD_ERR, WR_DATA} !== {3'b100, 8'h3C}) begin
            n_fail++;
            $display("[TB] FAIL par_ignore: got %b %h expected 100 3c", {WR_EN, BUSY, CMD_ERR}, WR_DATA);
        end
`endif
        @(negedge CLK);
    endtask

    initial begin
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        PAR_ERR   = 1'b0;
        FRM_ERR   = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_bad_cmd();
        test_timeout();
        test_byte_beats_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_rx_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
